// File: rtl/frame_buffer_scheduler_if.sv
// Handshake bundle between the ping-pong frame buffer scheduler, the disparity
// writer, the BRAM read port and the downstream filter.
interface frame_buffer_scheduler_if #(
    parameter int addr_w = 16
);
    logic              wr_frame_done;
    logic              wr_buf;
    logic [addr_w-1:0] rd_addr;
    logic              rd_en;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_last;
    logic [7:0]        drop_count;
    logic              busy;

    modport master (
        input  wr_frame_done, out_ready,
        output wr_buf, rd_addr, rd_en, out_valid, out_sof, out_last, drop_count, busy
    );

    modport slave (
        output wr_frame_done, out_ready,
        input  wr_buf, rd_addr, rd_en, out_valid, out_sof, out_last, drop_count, busy
    );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// Ping-pong frame buffer scheduler: picks the writer's buffer half, drops frames on
// overrun and issues a paced, backpressured column-major read of the completed half.
module frame_buffer_scheduler #(
    parameter int width  = 120,
    parameter int height = 240,
    parameter int pace   = 4,
    parameter int addr_w = $clog2(2 * width * height)
) (
    input  logic                    clk,
    input  logic                    reset,
    frame_buffer_scheduler_if.master bus
);
    localparam int col_w = (width  > 1) ? $clog2(width)  : 1;
    localparam int row_w = (height > 1) ? $clog2(height) : 1;
    localparam int pc_w  = (pace   > 1) ? $clog2(pace)   : 1;
    localparam logic [pc_w-1:0]  pace_top = pc_w'(pace - 1);
    localparam logic [col_w-1:0] col_top  = col_w'(width - 1);
    localparam logic [row_w-1:0] row_top  = row_w'(height - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state;
    logic [1:0]        full;
    logic              wr_buf;
    logic              rd_buf;
    logic [col_w-1:0]  col;
    logic [row_w-1:0]  row;
    logic [pc_w-1:0]   pace_cnt;
    logic              out_valid;
    logic              out_sof;
    logic              out_last;
    logic [7:0]        drop_count;

    logic other;
    logic first_pix;
    logic last_pix;
    logic accept_last;
    logic issue;
    logic other_free;
    logic [addr_w-1:0] base;

    assign other       = ~wr_buf;
    assign first_pix   = (row == '0) && (col == '0);
    assign last_pix    = (row == row_top) && (col == col_top);
    assign accept_last = out_valid && bus.out_ready && out_last && (state == DRAIN);
    // rd_en must react to out_ready in the same cycle, otherwise a stalled pixel
    // in the BRAM output register would be overwritten by an in-flight read.
    assign issue       = (state == READ) && (pace_cnt == pace_top) && (!out_valid || bus.out_ready);
    // An out_last acceptance this cycle frees the buffer it came from.
    assign other_free  = (!full[other] && !((state != IDLE) && (rd_buf == other)))
                       || (accept_last && (rd_buf == other));

    assign base = rd_buf ? addr_w'(width * height) : '0;

    assign bus.rd_addr    = base + addr_w'(row) * addr_w'(width) + addr_w'(col);
    assign bus.rd_en      = issue;
    assign bus.wr_buf     = wr_buf;
    assign bus.out_valid  = out_valid;
    assign bus.out_sof    = out_sof;
    assign bus.out_last   = out_last;
    assign bus.drop_count = drop_count;
    assign bus.busy       = (state == READ);

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            full       <= '0;
            wr_buf     <= 1'b0;
            rd_buf     <= 1'b0;
            col        <= '0;
            row        <= '0;
            pace_cnt   <= pace_top;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_last   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (issue) begin
                pace_cnt <= '0;
            end else if (pace_cnt != pace_top) begin
                pace_cnt <= pace_cnt + 1'b1;
            end

            if (bus.wr_frame_done) begin
                if (other_free) begin
                    full[wr_buf] <= 1'b1;
                    wr_buf       <= other;
                end else if (drop_count != 8'hff) begin
                    drop_count <= drop_count + 8'd1;
                end
            end

            if (accept_last) begin
                full[rd_buf] <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (full[other]) begin
                        rd_buf <= other;
                        col    <= '0;
                        row    <= '0;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        // Column-major scan: walk down the rows, then step one column.
                        if (row == row_top) begin
                            row <= '0;
                            col <= (col == col_top) ? '0 : col + 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                        if (last_pix) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                out_valid <= 1'b1;
                out_sof   <= first_pix;
                out_last  <= last_pix;
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Self-checking bench for frame_buffer_scheduler: a per-cycle vector table for the
// first backpressured frame plus hand sequences for pacing, overrun and reset.
module tb_frame_buffer_scheduler;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = $clog2(2 * W * H);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frame_buffer_scheduler_if #(.addr_w(AW)) bus1 ();
    frame_buffer_scheduler_if #(.addr_w(AW)) bus4 ();

    frame_buffer_scheduler #(.width(W), .height(H), .pace(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    frame_buffer_scheduler #(.width(W), .height(H), .pace(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // BRAM model content: any injective function of the address.
    function automatic logic [15:0] mem_val(input int a);
        return 16'(a * 7 + 3);
    endfunction

    logic [15:0] rd_data1, rd_data4;
    always @(posedge clk) if (bus1.rd_en) rd_data1 <= mem_val(int'(bus1.rd_addr));
    always @(posedge clk) if (bus4.rd_en) rd_data4 <= mem_val(int'(bus4.rd_addr));

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        last;
    } pix_t;

    pix_t q1[$];
    pix_t q4[$];
    int   a1[$];
    int   t1[$];
    int   t4[$];

    task automatic push_frame(input int which, input int b);
        pix_t p;
        for (int c = 0; c < W; c++) begin
            for (int r = 0; r < H; r++) begin
                p.data = mem_val(b * W * H + r * W + c);
                p.sof  = (c == 0) && (r == 0);
                p.last = (c == W - 1) && (r == H - 1);
                if (which == 1) q1.push_back(p);
                else            q4.push_back(p);
            end
        end
    endtask

    pix_t p1, p4;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus1.out_valid && bus1.out_ready) begin
                if (q1.size() == 0) check("dut1 unexpected pixel", 1, 0);
                else begin
                    p1 = q1.pop_front();
                    check("dut1 pixel", {rd_data1, bus1.out_sof, bus1.out_last}, {p1.data, p1.sof, p1.last});
                end
            end
            if (bus1.rd_en) begin
                a1.push_back(int'(bus1.rd_addr));
                t1.push_back(cyc);
            end
            if (bus4.out_valid && bus4.out_ready) begin
                if (q4.size() == 0) check("dut4 unexpected pixel", 1, 0);
                else begin
                    p4 = q4.pop_front();
                    check("dut4 pixel", {rd_data4, bus4.out_sof, bus4.out_last}, {p4.data, p4.sof, p4.last});
                end
            end
            if (bus4.rd_en) t4.push_back(cyc);
        end
    end

    typedef struct {
        bit wfd;
        bit rdy;
        bit en;
        bit ca;
        int addr;
        bit ov;
        bit sof;
        bit last;
        bit wb;
        bit busy;
    } vec_t;

    function automatic vec_t mk(bit wfd, bit rdy, bit en, bit ca, int addr,
                                bit ov, bit sof, bit last, bit wb, bit busy);
        vec_t v;
        v.wfd = wfd; v.rdy = rdy; v.en = en; v.ca = ca; v.addr = addr;
        v.ov = ov; v.sof = sof; v.last = last; v.wb = wb; v.busy = busy;
        return v;
    endfunction

    vec_t vt[21];
    int   seq_a[17] = '{0, 4, 8, 1, 1, 1, 1, 1, 1, 5, 9, 2, 6, 10, 3, 7, 11};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit bp;

        // Cycle-by-cycle expectations for frame 0 of dut1 with a 5-cycle stall.
        vt[0] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        vt[1] = mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        for (int r = 2; r <= 18; r++) begin
            bp = (r >= 5) && (r <= 9);
            vt[r] = mk(0, !bp, !bp, 1, seq_a[r - 2], r >= 3, r == 3, 0, 1, 1);
        end
        vt[19] = mk(0, 1, 0, 0, 0, 1, 0, 1, 1, 0);
        vt[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);

        reset = 1'b1;
        bus1.wr_frame_done = 1'b0;
        bus1.out_ready     = 1'b1;
        bus4.wr_frame_done = 1'b0;
        bus4.out_ready     = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle dut1", {bus1.rd_en, bus1.rd_addr, bus1.out_valid, bus1.out_sof, bus1.out_last,
                                bus1.drop_count, bus1.busy, bus1.wr_buf}, 0);
            check("idle dut4", {bus4.rd_en, bus4.rd_addr, bus4.out_valid, bus4.out_sof, bus4.out_last,
                                bus4.drop_count, bus4.busy, bus4.wr_buf}, 0);
        end

        for (int i = 0; i < 21; i++) begin
            tick();
            bus1.wr_frame_done = vt[i].wfd;
            bus1.out_ready     = vt[i].rdy;
            if (vt[i].wfd) push_frame(1, 0);
            @(negedge clk);
            check($sformatf("vec%0d ctl", i),
                  {bus1.rd_en, bus1.out_valid, bus1.out_sof, bus1.out_last, bus1.wr_buf, bus1.busy},
                  {vt[i].en, vt[i].ov, vt[i].sof, vt[i].last, vt[i].wb, vt[i].busy});
            if (vt[i].ca) check($sformatf("vec%0d addr", i), bus1.rd_addr, vt[i].addr);
        end
        check("dut1 frame0 pixels left", q1.size(), 0);

        // Second frame lands in buffer 1 and is read back-to-back.
        a1.delete();
        t1.delete();
        tick();
        bus1.wr_frame_done = 1'b1;
        push_frame(1, 1);
        tick();
        bus1.wr_frame_done = 1'b0;
        @(negedge clk);
        check("dut1 wr_buf after frame1", bus1.wr_buf, 0);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = (a1.size() == W * H) && (q1.size() == 0) && !bus1.busy;
        end
        check("dut1 frame1 drain timeout", ok, 1);
        check("dut1 frame1 reads", a1.size(), W * H);
        for (int k = 0; k < a1.size() && k < W * H; k++) begin
            check($sformatf("dut1 frame1 addr%0d", k), a1[k], W * H + (k % H) * W + (k / H));
            check($sformatf("dut1 frame1 gap%0d", k), t1[k] - t1[0], k);
        end

        // Paced reader with overruns on dut4.
        t4.delete();
        tick();
        bus4.wr_frame_done = 1'b1;
        push_frame(4, 0);
        tick();
        bus4.wr_frame_done = 1'b0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = (t4.size() >= 3);
        end
        check("dut4 start timeout", ok, 1);
        bus4.wr_frame_done = 1'b1;
        tick();
        bus4.wr_frame_done = 1'b0;
        @(negedge clk);
        check("overrun1 wr_buf", bus4.wr_buf, 1);
        check("overrun1 drop_count", bus4.drop_count, 1);
        tick();
        bus4.wr_frame_done = 1'b1;
        tick();
        bus4.wr_frame_done = 1'b0;
        @(negedge clk);
        check("overrun2 drop_count", bus4.drop_count, 2);

        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            ok = (t4.size() == W * H) && (q4.size() == 0) && !bus4.busy && !bus4.out_valid;
        end
        check("dut4 frame0 drain timeout", ok, 1);
        check("dut4 frame0 reads", t4.size(), W * H);
        for (int k = 1; k < t4.size(); k++)
            check($sformatf("dut4 pace gap%0d", k), t4[k] - t4[k - 1], 4);

        tick();
        bus4.wr_frame_done = 1'b1;
        push_frame(4, 1);
        tick();
        bus4.wr_frame_done = 1'b0;
        @(negedge clk);
        check("post-drain wr_buf", bus4.wr_buf, 0);
        check("post-drain drop_count", bus4.drop_count, 2);

        // Frame completes in the same cycle out_last of buffer 1 is accepted.
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            ok = bus4.out_valid && bus4.out_last;
        end
        check("dut4 out_last timeout", ok, 1);
        bus4.wr_frame_done = 1'b1;
        push_frame(4, 0);
        tick();
        bus4.wr_frame_done = 1'b0;
        @(negedge clk);
        check("same-cycle wr_buf", bus4.wr_buf, 1);
        check("same-cycle drop_count", bus4.drop_count, 2);

        // Stall the next read and flood with overruns.
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = bus4.out_valid;
        end
        check("dut4 stall timeout", ok, 1);
        bus4.out_ready = 1'b0;
        for (int n = 0; n < 300; n++) begin
            bus4.wr_frame_done = 1'b1;
            tick();
            bus4.wr_frame_done = 1'b0;
            tick();
        end
        @(negedge clk);
        check("saturated drop_count", bus4.drop_count, 255);
        check("stalled state", {bus4.out_valid, bus4.busy, bus4.wr_buf, bus4.rd_en}, 4'b1110);

        // Reset in the middle of a frame aborts it without flushing.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus4.out_ready = 1'b1;
        q4.delete();
        t4.delete();
        @(negedge clk);
        check("mid-frame reset dut4", {bus4.rd_en, bus4.rd_addr, bus4.out_valid, bus4.out_sof, bus4.out_last,
                                       bus4.drop_count, bus4.busy, bus4.wr_buf}, 0);
        repeat (10) tick();
        check("no read after reset", t4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
